// File: rtl/sine_pwm_dac.sv
// Sine-sample PWM DAC: scales each sample by (amplitude+1)/256 and emits one PWM
// period per latched sample, pulsing sample_req_o whenever a new duty is taken.
module sine_pwm_dac #(
  parameter int SAMPLE_WIDTH   = 8,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable_i,
  input  logic [SAMPLE_WIDTH-1:0]   sample_i,
  input  logic [SAMPLE_WIDTH-1:0]   amplitude_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  output logic                      pwm_out_o,
  output logic                      sample_req_o,
  output logic [SAMPLE_WIDTH-1:0]   period_count_o
);

  localparam int ProdWidth = 2 * SAMPLE_WIDTH + 1;
  localparam logic [SAMPLE_WIDTH-1:0] CntMax = {SAMPLE_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_t;

  state_t                    stateQ, stateD;
  logic [SAMPLE_WIDTH-1:0]   cntQ, cntD;
  logic [PRESCALE_WIDTH-1:0] preQ, preD;
  logic [SAMPLE_WIDTH-1:0]   dutyQ, dutyD;
  logic [PRESCALE_WIDTH-1:0] prescLQ, prescLD;
  logic                      pwmQ, pwmD;
  logic                      reqQ, reqD;

  logic [ProdWidth-1:0]      product;
  logic [SAMPLE_WIDTH-1:0]   scaledDuty;
  logic                      tick;
  logic                      wrap;

  // Gain is amplitude+1 so that full scale passes the sample through untouched.
  always_comb begin
    product    = ProdWidth'(sample_i) * (ProdWidth'(amplitude_i) + ProdWidth'(1));
    scaledDuty = SAMPLE_WIDTH'(product >> SAMPLE_WIDTH);
    tick       = (preQ == prescLQ);
    wrap       = tick && (cntQ == CntMax);
  end

  always_comb begin
    stateD  = stateQ;
    cntD    = cntQ;
    preD    = preQ;
    dutyD   = dutyQ;
    prescLD = prescLQ;
    pwmD    = pwmQ;
    reqD    = 1'b0;

    case (stateQ)
      IDLE: begin
        cntD = '0;
        preD = '0;
        pwmD = 1'b0;
        if (enable_i) begin
          stateD = LOAD;
        end
      end

      LOAD: begin
        cntD    = '0;
        preD    = '0;
        pwmD    = 1'b0;
        dutyD   = scaledDuty;
        prescLD = prescale_i;
        if (enable_i) begin
          reqD   = 1'b1;
          stateD = RUN;
        end else begin
          stateD = IDLE;
        end
      end

      RUN: begin
        // Dropping enable wins over a coincident wrap: no request is issued.
        if (!enable_i) begin
          stateD = IDLE;
          cntD   = '0;
          preD   = '0;
          pwmD   = 1'b0;
        end else begin
          pwmD = (cntQ < dutyQ);
          if (tick) begin
            preD = '0;
            if (wrap) begin
              cntD    = '0;
              dutyD   = scaledDuty;
              prescLD = prescale_i;
              reqD    = 1'b1;
            end else begin
              cntD = cntQ + 1'b1;
            end
          end else begin
            preD = preQ + 1'b1;
          end
        end
      end

      default: begin
        stateD = IDLE;
        cntD   = '0;
        preD   = '0;
        pwmD   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateQ  <= IDLE;
      cntQ    <= '0;
      preQ    <= '0;
      dutyQ   <= '0;
      prescLQ <= '0;
      pwmQ    <= 1'b0;
      reqQ    <= 1'b0;
    end else begin
      stateQ  <= stateD;
      cntQ    <= cntD;
      preQ    <= preD;
      dutyQ   <= dutyD;
      prescLQ <= prescLD;
      pwmQ    <= pwmD;
      reqQ    <= reqD;
    end
  end

  assign pwm_out_o      = pwmQ;
  assign sample_req_o   = reqQ;
  assign period_count_o = cntQ;

endmodule

// File: doc/sine_pwm_dac.md
Name: sine_pwm_dac

Overview:
Downstream stage of the sine table generator. Consumes its 8-bit unsigned sine samples and produces a single-bit PWM stream for an external RC-filter DAC. Each sample is amplitude-scaled and latched once per PWM period. A one-cycle sample_req strobe marks each latch so upstream logic can pace its sample stepping.

Parameters:
SAMPLE_WIDTH, 8, width of sample, amplitude, duty and PWM counter
PRESCALE_WIDTH, 8, width of the prescale input and prescaler counter

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
enable  in  1  run request; low forces IDLE
sample  in  SAMPLE_WIDTH  unsigned sine sample from generator
amplitude  in  SAMPLE_WIDTH  gain; effective gain (amplitude+1)/256
prescale  in  PRESCALE_WIDTH  clocks per PWM count minus 1
pwm_out  out  1  registered PWM output
sample_req  out  1  one-cycle pulse on each duty latch
period_count  out  SAMPLE_WIDTH  current PWM counter value (cnt)

Behaviour:
- Reset: async, active-high. State=IDLE. cnt, pre, duty, presc_l, pwm_out, sample_req and period_count all 0. Asserting reset mid-period clears everything immediately, with no completion of the current period.
- Scaling: duty = (sample * (amplitude+1)) >> 8.
  - Full-precision product (SAMPLE_WIDTH*2+1 bits), truncation, no rounding.
  - amplitude=255 gives duty=sample exactly.
- States: IDLE, LOAD, RUN. Transitions below are evaluated at the rising edge.
- IDLE:
  - cnt, pre, pwm_out and sample_req are held at 0.
  - enable=1 moves to LOAD.
- LOAD (exactly one cycle):
  - duty <= scaled(sample, amplitude); presc_l <= prescale; cnt <= 0; pre <= 0; sample_req <= 1.
  - Next state is RUN; if enable=0, IDLE instead.
- RUN, every edge:
  - pwm_out <= (cnt < duty), comparing the pre-edge register values. pwm_out therefore lags cnt by one clock.
  - Prescaler: if pre == presc_l, then pre <= 0 and tick=1; otherwise pre <= pre+1.
  - On tick with cnt < 255: cnt <= cnt+1.
  - On tick with cnt == 255 (period wrap):
    - cnt <= 0.
    - duty and presc_l are re-latched from the current sample, amplitude and prescale.
    - sample_req <= 1.
  - sample_req <= 0 on every edge not listed above, so the pulse is exactly one cycle wide.
- Period and duty:
  - Period = 256*(presc_l+1) clocks.
  - High time = duty*(presc_l+1) clocks.
  - duty=0 gives constant low; duty=255 gives high for 255 of 256 counts.
  - A 100% duty cycle is not reachable, by design.
- Register timing:
  - sample, amplitude and prescale are sampled only at LOAD and at period wrap.
  - Changes between those points are ignored until the next wrap.
- enable deasserted in RUN: at the next edge, state=IDLE and pwm_out, sample_req, cnt and pre become 0. duty keeps its value but is unused.
- Re-enable: always passes through LOAD, so a new sample is latched and a new period starts at cnt=0.
- Simultaneous wrap and enable=0: IDLE wins and no sample_req is issued.
- period_count equals cnt. It is 0 outside RUN.

Test Plan:
1. Reset, then enable=1, sample=128, amplitude=255, prescale=0:
   - sample_req pulses the cycle after LOAD, then every 256 clocks.
   - pwm_out is high for exactly 128 consecutive clocks per period.
2. sample=0, amplitude=255 -> pwm_out stays 0 over 3 periods. sample=255 -> high 255 clocks, low 1 clock per period.
3. sample=200, amplitude=127, prescale=0 -> duty=100, with 100 high clocks per 256. amplitude=0 and sample=255 -> duty=0.
4. prescale=3, sample=64 -> period 1024 clocks, high 256 clocks.
   - Change prescale to 0 at cnt=100: the current period still completes at 1024 clocks.
   - The next period is 256 clocks long.
5. Drop enable at cnt=50 -> next edge: pwm_out=0, period_count=0, no sample_req.
   - Re-enable with sample=32 -> LOAD pulse, then 32 high clocks.
   - Drop enable on the wrap edge -> no sample_req.
6. Assert reset asynchronously mid-high-phase -> pwm_out, sample_req and period_count go 0 without waiting for a clock edge.
   - Release reset with enable=1 -> IDLE, then LOAD, then RUN.
